// File: rtl/sipo_rx.sv
// sipo_rx: MSB-first serial-to-parallel receive stage.
// Reassembles words from a qualified serial stream and presents them on a held
// parallel register with a valid/ready handshake. It also flags framing resyncs
// and dropped words.
// Optional feature: define SIPO_PARITY_EN to expect one trailing even-parity bit
// per word. parity_err then reports the parity check result for the word in dout.
// All registers update on the falling clock edge, the same edge as the upstream shifter.
module sipo_rx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_en,
  input  logic             start,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err,
  output logic             parity_err
);

`ifdef SIPO_PARITY_EN
  localparam int N = WIDTH + 1;   // data bits plus trailing parity bit
`else
  localparam int N = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 2);
  // Count value held just before the final bit of a word is accepted.
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  // Only the N-1 most recent bits need storing; the incoming bit completes the word.
  logic [N-2:0]    sr;
  logic [N-1:0]    sr_next;
  logic [WIDTH-1:0] word;
  logic            take;

`ifdef SIPO_PARITY_EN
  // Reduction XOR over data and parity bits; 1 means the even-parity check failed.
  function automatic logic parity_fail(input logic [N-1:0] v);
    return ^v;
  endfunction
`endif

  // Assemble the candidate word from stored bits plus the bit on sin this cycle.
  always_comb begin
    sr_next = {sr, sin};
`ifdef SIPO_PARITY_EN
    word = sr_next[N-1:1];
`else
    word = sr_next;
`endif
    // A finished word may load dout if the slot is empty or is being drained now.
    take = !dout_valid || dout_ready;
  end

`ifndef SIPO_PARITY_EN
  assign parity_err = 1'b0;
`endif

  // Receive control: bit capture, resync, word completion, handshake and status flags.
  always_ff @(negedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= {CW{1'b0}};
      sr         <= {(N-1){1'b0}};
      dout       <= {WIDTH{1'b0}};
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
`ifdef SIPO_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      // Consumer drains the held word; a completion below may reload it in the same edge.
      if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
`ifdef SIPO_PARITY_EN
        parity_err <= 1'b0;
`endif
      end
      if (sin_en) begin
        case (state)
          IDLE: begin
            // Bits without start are ignored while idle.
            if (start) begin
              sr    <= {{(N-2){1'b0}}, sin};
              cnt   <= CW'(1);
              state <= SHIFT;
              busy  <= 1'b1;
            end
          end
          SHIFT: begin
            if (start) begin
              // Start mid-word: drop the partial word and restart from this bit.
              frame_err <= 1'b1;
              sr        <= {{(N-2){1'b0}}, sin};
              cnt       <= CW'(1);
            end else if (cnt == LAST) begin
              sr    <= sr_next[N-2:0];
              cnt   <= {CW{1'b0}};
              state <= IDLE;
              busy  <= 1'b0;
              if (take) begin
                dout       <= word;
                dout_valid <= 1'b1;
`ifdef SIPO_PARITY_EN
                parity_err <= parity_fail(sr_next);
`endif
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              sr  <= sr_next[N-2:0];
              cnt <= cnt + CW'(1);
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= {CW{1'b0}};
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sipo_rx.sv
// tb_sipo_rx: randomized scoreboard bench for sipo_rx.
// The stimulus side drives inputs at the rising edge, one half-cycle ahead of the
// DUT's falling edge. At the same time it updates a word-level reference model and
// queues the expected status and any completed word. A monitor samples just after
// each falling edge, pops those expectations and compares them.
module tb_sipo_rx;
  localparam int WIDTH = 8;
`ifdef SIPO_PARITY_EN
  localparam int N = WIDTH + 1;
  localparam bit PAR = 1'b1;
`else
  localparam int N = WIDTH;
  localparam bit PAR = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             sin = 1'b0;
  logic             sin_en = 1'b0;
  logic             start = 1'b0;
  logic             dout_ready = 1'b0;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             busy;
  logic             overrun;
  logic             frame_err;
  logic             parity_err;

  sipo_rx #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .sin(sin), .sin_en(sin_en), .start(start),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .busy(busy), .overrun(overrun), .frame_err(frame_err), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             busy;
    logic             ovr;
    logic             fe;
    logic             valid;
    logic             perr;
    logic [WIDTH-1:0] dout;
  } flags_t;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             perr;
  } word_t;

  flags_t flag_q[$];
  word_t  word_q[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference model: bits collected for the word in flight, plus the output slot.
  int               m_cnt = 0;
  longint           m_bits = 0;
  bit               m_slot = 1'b0;
  bit               m_ovr = 1'b0;
  bit               m_perr = 1'b0;
  logic [WIDTH-1:0] m_dout = '0;
  int               rdy_mode = 0;   // 0: ready low, 1: ready high, 2: random

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus plus the model's view of the following falling edge.
  task automatic tick(input logic b, input logic en, input logic st, input logic r);
    logic   rdy;
    bit     fe;
    bit     slot_after;
    flags_t f;
    word_t  w;
    @(posedge clk);
    case (rdy_mode)
      0:       rdy = 1'b0;
      1:       rdy = 1'b1;
      default: rdy = 1'($urandom_range(0, 1));
    endcase
    sin = b; sin_en = en; start = st; dout_ready = rdy; rst = r;
    fe = 1'b0;
    if (r) begin
      m_cnt = 0; m_bits = 0; m_slot = 1'b0; m_ovr = 1'b0; m_perr = 1'b0; m_dout = '0;
    end else begin
      slot_after = m_slot && !rdy;
      if (!slot_after) m_perr = 1'b0;
      if (en) begin
        if (st) begin
          fe = (m_cnt > 0);
          m_bits = longint'(b);
          m_cnt = 1;
        end else if (m_cnt > 0) begin
          m_bits = (m_bits << 1) | longint'(b);
          m_cnt++;
        end
        if (m_cnt == N) begin
          if (m_slot && !rdy) begin
            m_ovr = 1'b1;
          end else begin
            w.data = PAR ? WIDTH'(m_bits >> 1) : WIDTH'(m_bits);
            w.perr = PAR ? 1'($countones(m_bits) % 2) : 1'b0;
            m_dout = w.data;
            m_perr = w.perr;
            word_q.push_back(w);
            slot_after = 1'b1;
          end
          m_cnt = 0;
        end
      end
      m_slot = slot_after;
    end
    f.busy = (m_cnt > 0); f.ovr = m_ovr; f.fe = fe; f.valid = m_slot;
    f.perr = m_perr; f.dout = m_dout;
    flag_q.push_back(f);
  endtask

  // Send one word MSB first with start on the first bit; optional idle gaps and bad parity.
  task automatic send_word(input logic [WIDTH-1:0] w, input int gap, input bit flip);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      while (gap > 0 && $urandom_range(0, 99) < gap)
        tick(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), 1'b0);
      tick(w[i], 1'b1, (i == WIDTH - 1), 1'b0);
    end
    if (PAR) tick((^w) ^ flip, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic send_partial(input int k);
    for (int i = 0; i < k; i++)
      tick(1'($urandom_range(0, 1)), 1'b1, (i == 0), 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compare status every edge; compare each newly presented word once.
  initial begin : monitor
    bit     seen = 1'b0;
    flags_t e;
    word_t  w;
    forever begin
      @(negedge clk);
      #1;
      if (rst || dout_ready) seen = 1'b0;
      if (flag_q.size() > 0) begin
        e = flag_q.pop_front();
        vectors++;
        chk("busy", 32'(busy), 32'(e.busy));
        chk("overrun", 32'(overrun), 32'(e.ovr));
        chk("frame_err", 32'(frame_err), 32'(e.fe));
        chk("dout_valid", 32'(dout_valid), 32'(e.valid));
        chk("parity_err", 32'(parity_err), 32'(e.perr));
        chk("dout", 32'(dout), 32'(e.dout));
      end
      if (dout_valid === 1'b1 && !seen) begin
        seen = 1'b1;
        vectors++;
        if (word_q.size() == 0) begin
          miscompares++;
          $display("FAIL word: got unexpected dout %0h, required no word", dout);
        end else begin
          w = word_q.pop_front();
          chk("word_data", 32'(dout), 32'(w.data));
          chk("word_parity", 32'(parity_err), 32'(w.perr));
        end
      end
    end
  end

  initial begin : stim
    int r;
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);
    // Basic word, consumer not yet ready: must hold.
    rdy_mode = 0;
    send_word(8'hA5, 0, 1'b0);
    idle(2);
    rdy_mode = 1;
    idle(2);
    // Back-to-back with ready held high.
    send_word(8'h3C, 0, 1'b0);
    send_word(8'hC3, 0, 1'b0);
    idle(2);
    // Overrun: second word dropped, overrun sticky after drain.
    rdy_mode = 0;
    send_word(8'h11, 0, 1'b0);
    send_word(8'h22, 0, 1'b0);
    idle(1);
    rdy_mode = 1;
    idle(3);
    // Resync after 3 bits.
    send_partial(3);
    send_word(8'hF0, 0, 1'b0);
    idle(2);
    // Reset mid-word after 4 bits.
    send_partial(4);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    send_word(8'h5A, 0, 1'b0);
    idle(2);
    // Parity good then bad (only meaningful with parity enabled).
    send_word(8'hA5, 0, 1'b0);
    send_word(8'hA5, 0, 1'b1);
    idle(2);
    // Ready tied high: long back-to-back stream, overrun must stay 0.
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) send_word(WIDTH'($urandom), 0, 1'($urandom_range(0, 1)));
    // Randomized traffic with gaps, resyncs, resets and random ready.
    rdy_mode = 2;
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 99);
      if (r < 10) send_partial($urandom_range(1, N - 1));
      else if (r < 14) tick(1'b0, 1'b0, 1'b0, 1'b1);
      else if (r < 20) idle($urandom_range(1, 3));
      send_word(WIDTH'($urandom), 20, ($urandom_range(0, 3) == 0));
    end
    rdy_mode = 1;
    idle(3);
    @(negedge clk);
    #2;
    vectors++;
    chk("pending_words", 32'(word_q.size()), 32'd0);
    vectors++;
    chk("pending_flags", 32'(flag_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
